// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing with sync/blank delayed to match renderer latency
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RENDER_LAT = 2,
  parameter int FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [9:0]        o_pix_x,
  output logic [9:0]        o_pix_y,
  output logic              o_pix_active,
  output logic              o_line_start,
  output logic              o_frame_start,
  output logic [FCNT_W-1:0] o_frame_cnt,
  input  logic [3:0]        i_red,
  input  logic [3:0]        i_green,
  input  logic [3:0]        i_blue,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic [3:0]        o_red,
  output logic [3:0]        o_green,
  output logic [3:0]        o_blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Flag bundle order: {hsync, vsync, active}; idle value is sync high, blanked.
  localparam logic [2:0] FLAGS_IDLE = 3'b110;

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [2:0] cur_flags;
  logic [2:0] dly_flags;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      o_frame_cnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      if (vcnt == V_LAST) begin
        vcnt        <= '0;
        o_frame_cnt <= o_frame_cnt + FCNT_W'(1);
      end else begin
        vcnt <= vcnt + 10'd1;
      end
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  always_comb begin
    o_pix_x       = hcnt;
    o_pix_y       = vcnt;
    o_pix_active  = (hcnt < H_ACT) && (vcnt < V_ACT);
    o_line_start  = (hcnt == 10'd0);
    o_frame_start = (hcnt == 10'd0) && (vcnt == 10'd0);
    cur_flags     = {!((hcnt >= HS_START) && (hcnt < HS_END)),
                     !((vcnt >= VS_START) && (vcnt < VS_END)),
                     o_pix_active};
  end

  // Sync and blanking travel alongside the renderer's pipeline so colour and sync leave together.
  generate
    if (RENDER_LAT == 0) begin : g_no_delay
      assign dly_flags = cur_flags;
    end else begin : g_delay
      logic [2:0] pipe [RENDER_LAT];

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < RENDER_LAT; i++) pipe[i] <= FLAGS_IDLE;
        end else begin
          pipe[0] <= cur_flags;
          for (int i = 1; i < RENDER_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dly_flags = pipe[RENDER_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
      o_red   <= 4'h0;
      o_green <= 4'h0;
      o_blue  <= 4'h0;
    end else begin
      o_hsync <= dly_flags[2];
      o_vsync <= dly_flags[1];
      if (dly_flags[0]) begin
        o_red   <= i_red;
        o_green <= i_green;
        o_blue  <= i_blue;
      end else begin
        o_red   <= 4'h0;
        o_green <= 4'h0;
        o_blue  <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of VGA timing, colour alignment, reset and frame counter wrap
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int LAT  = 2;
  localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VA = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
  localparam int S_HA = 16,  S_HF = 4,  S_HS = 6,  S_HB = 6;
  localparam int S_VA = 6,   S_VF = 1,  S_VS = 2,  S_VB = 3;
  localparam int S_HT = 32,  S_VT = 12, S_FRAME = 384;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #20 clk = ~clk;

  logic [9:0]  d_x, d_y;
  logic        d_act, d_ls, d_fs, d_hs, d_vs;
  logic [15:0] d_fc;
  logic [3:0]  d_ir, d_ig, d_ib, d_r, d_g, d_b;
  logic [9:0]  s_x, s_y;
  logic        s_act, s_ls, s_fs, s_hs, s_vs;
  logic [1:0]  s_fc;
  logic [3:0]  s_ir, s_ig, s_ib, s_r, s_g, s_b;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .o_pix_x(d_x), .o_pix_y(d_y), .o_pix_active(d_act),
    .o_line_start(d_ls), .o_frame_start(d_fs), .o_frame_cnt(d_fc),
    .i_red(d_ir), .i_green(d_ig), .i_blue(d_ib),
    .o_hsync(d_hs), .o_vsync(d_vs), .o_red(d_r), .o_green(d_g), .o_blue(d_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .RENDER_LAT(LAT), .FCNT_W(2)
  ) dut_s (
    .clk(clk), .rst(rst), .o_pix_x(s_x), .o_pix_y(s_y), .o_pix_active(s_act),
    .o_line_start(s_ls), .o_frame_start(s_fs), .o_frame_cnt(s_fc),
    .i_red(s_ir), .i_green(s_ig), .i_blue(s_ib),
    .o_hsync(s_hs), .o_vsync(s_vs), .o_red(s_r), .o_green(s_g), .o_blue(s_b)
  );

  // Renderer stand-in: red=x[3:0], green=y[3:0], two cycles late.
  logic [3:0] d_r1 = '0, d_r2 = '0, d_g1 = '0, d_g2 = '0;
  logic [3:0] s_r1 = '0, s_r2 = '0, s_g1 = '0, s_g2 = '0;
  always @(posedge clk) begin
    d_r1 <= d_x[3:0]; d_r2 <= d_r1; d_g1 <= d_y[3:0]; d_g2 <= d_g1;
    s_r1 <= s_x[3:0]; s_r2 <= s_r1; s_g1 <= s_y[3:0]; s_g2 <= s_g1;
  end
  assign d_ir = d_r2;
  assign d_ig = d_g2;
  assign s_ir = s_r2;
  assign s_ig = s_g2;

  wire [13:0] d_pins  = {d_hs, d_vs, d_r, d_g, d_b};
  wire [13:0] s_pins  = {s_hs, s_vs, s_r, s_g, s_b};
  wire [22:0] d_coord = {d_x, d_y, d_act, d_ls, d_fs};
  wire [22:0] s_coord = {s_x, s_y, s_act, s_ls, s_fs};

  // Expected pins k cycles after the last reset edge: {hsync, vsync, red, green, blue}.
  function automatic logic [13:0] exp_pins(input int k, input int ha, hf, hsw, hb, va, vf, vsw, vb);
    int ht, vt, t, x, y;
    logic act;
    logic [3:0] xr, yr;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (k < LAT + 1) return 14'h3000;
    t  = k - LAT - 1;
    x  = t % ht;
    y  = (t / ht) % vt;
    xr = x[3:0];
    yr = y[3:0];
    act = (x < ha) && (y < va);
    return {!(x >= ha + hf && x < ha + hf + hsw), !(y >= va + vf && y < va + vf + vsw),
            act ? {xr, yr, 4'hF} : 12'h000};
  endfunction

  // Expected {x, y, active, line_start, frame_start} k cycles after the last reset edge.
  function automatic logic [22:0] exp_coord(input int k, input int ha, ht, va, vt);
    int x, y;
    logic [9:0] xs, ys;
    x  = k % ht;
    y  = (k / ht) % vt;
    xs = 10'(x);
    ys = 10'(y);
    return {xs, ys, (x < ha) && (y < va), x == 0, (x == 0) && (y == 0)};
  endfunction

  task automatic apply_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset(3);
    checks++; if (d_pins !== 14'h3000) begin failures++; $display("FAIL reset_pins got=%h exp=3000", d_pins); end
    checks++; if (d_fc !== 16'h0) begin failures++; $display("FAIL reset_fcnt got=%h exp=0", d_fc); end
    checks++; if (d_x !== 10'd0 || d_y !== 10'd0) begin failures++; $display("FAIL reset_coord got=%0d,%0d exp=0,0", d_x, d_y); end
    checks++; if ({d_ls, d_fs} !== 2'b11) begin failures++; $display("FAIL reset_starts got=%b exp=11", {d_ls, d_fs}); end
    checks++; if (s_pins !== 14'h3000) begin failures++; $display("FAIL reset_pins_s got=%h exp=3000", s_pins); end
    checks++; if (s_fc !== 2'd0) begin failures++; $display("FAIL reset_fcnt_s got=%0d exp=0", s_fc); end
    checks++; if (s_x !== 10'd0 || s_y !== 10'd0) begin failures++; $display("FAIL reset_coord_s got=%0d,%0d exp=0,0", s_x, s_y); end
  endtask

  task automatic test_line_timing();
    int first_fall = -1, second_fall = -1, low_cnt = 0, ls_cnt = 0, first_ls = -1;
    logic prev_hs = 1'b1;
    logic [13:0] ep;
    logic [22:0] ec;
    apply_reset(1);
    rst = 1'b1;
    for (int k = 1; k <= 1700; k++) begin
      @(posedge clk); #1;
      ep = exp_pins(k, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB);
      ec = exp_coord(k, D_HA, 800, D_VA, 525);
      checks++; if (d_hs !== ep[13] || d_vs !== ep[12]) begin failures++; $display("FAIL line_sync k=%0d got=%b%b exp=%b", k, d_hs, d_vs, ep[13:12]); end
      checks++; if (d_coord !== ec) begin failures++; $display("FAIL line_coord k=%0d got=%h exp=%h", k, d_coord, ec); end
      if (prev_hs && !d_hs) begin
        if (first_fall < 0) first_fall = k; else if (second_fall < 0) second_fall = k;
      end
      if (!d_hs) low_cnt++;
      if (d_ls) begin ls_cnt++; if (first_ls < 0) first_ls = k; end
      prev_hs = d_hs;
    end
    checks++; if (first_fall != 659) begin failures++; $display("FAIL hsync_first_fall got=%0d exp=659", first_fall); end
    checks++; if (second_fall - first_fall != 800) begin failures++; $display("FAIL hsync_period got=%0d exp=800", second_fall - first_fall); end
    checks++; if (low_cnt != 192) begin failures++; $display("FAIL hsync_low_cycles got=%0d exp=192", low_cnt); end
    checks++; if (ls_cnt != 2 || first_ls != 800) begin failures++; $display("FAIL line_start got=%0d@%0d exp=2@800", ls_cnt, first_ls); end
  endtask

  task automatic test_alignment();
    int lit = 0;
    logic [13:0] ep;
    apply_reset(1);
    rst = 1'b1;
    for (int k = 1; k <= 1700; k++) begin
      @(posedge clk); #1;
      ep = exp_pins(k, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB);
      checks++; if (d_pins !== ep) begin failures++; $display("FAIL align_pins k=%0d got=%h exp=%h", k, d_pins, ep); end
      if (d_b == 4'hF) lit++;
    end
    checks++; if (lit != 1378) begin failures++; $display("FAIL align_lit_cycles got=%0d exp=1378", lit); end
  endtask

  task automatic test_frame_timing();
    int first_fall = -1, second_fall = -1, low_cnt = 0, fs_cnt = 0;
    logic prev_vs = 1'b1;
    logic [13:0] ep;
    logic [22:0] ec;
    logic [1:0]  ef;
    apply_reset(1);
    rst = 1'b1;
    for (int k = 1; k <= 800; k++) begin
      @(posedge clk); #1;
      ep = exp_pins(k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
      ec = exp_coord(k, S_HA, S_HT, S_VA, S_VT);
      ef = 2'((k / S_FRAME) % 4);
      checks++; if (s_pins !== ep) begin failures++; $display("FAIL frame_pins k=%0d got=%h exp=%h", k, s_pins, ep); end
      checks++; if (s_coord !== ec) begin failures++; $display("FAIL frame_coord k=%0d got=%h exp=%h", k, s_coord, ec); end
      checks++; if (s_fc !== ef) begin failures++; $display("FAIL frame_cnt k=%0d got=%0d exp=%0d", k, s_fc, ef); end
      if (prev_vs && !s_vs) begin
        if (first_fall < 0) first_fall = k; else if (second_fall < 0) second_fall = k;
      end
      if (!s_vs) low_cnt++;
      if (s_fs) fs_cnt++;
      prev_vs = s_vs;
    end
    checks++; if (first_fall != 227) begin failures++; $display("FAIL vsync_first_fall got=%0d exp=227", first_fall); end
    checks++; if (second_fall - first_fall != S_FRAME) begin failures++; $display("FAIL vsync_period got=%0d exp=384", second_fall - first_fall); end
    checks++; if (low_cnt != 128) begin failures++; $display("FAIL vsync_low_cycles got=%0d exp=128", low_cnt); end
    checks++; if (fs_cnt != 2) begin failures++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_wrap();
    logic [11:0] seq = '0;
    int nseq = 1, max_x = 0, max_y = 0;
    logic [1:0] prev = 2'd0;
    apply_reset(1);
    rst = 1'b1;
    for (int k = 1; k <= 5 * S_FRAME + 100; k++) begin
      @(posedge clk); #1;
      if (s_fc !== prev) begin seq = {seq[9:0], s_fc}; nseq++; prev = s_fc; end
      if (int'(s_x) > max_x) max_x = int'(s_x);
      if (int'(s_y) > max_y) max_y = int'(s_y);
    end
    checks++; if (nseq != 6 || seq !== 12'h1B1) begin failures++; $display("FAIL wrap_sequence got=%0d:%h exp=6:1b1", nseq, seq); end
    checks++; if (max_x != 31 || max_y != 11) begin failures++; $display("FAIL wrap_max_coord got=%0d,%0d exp=31,11", max_x, max_y); end
  endtask

  task automatic test_midframe_reset();
    logic [13:0] ep;
    logic [22:0] ec;
    apply_reset(1);
    rst = 1'b1;
    repeat (S_FRAME + 4 * S_HT + 10) @(posedge clk);
    #1;
    checks++; if (s_x !== 10'd10 || s_y !== 10'd4 || s_fc !== 2'd1) begin failures++; $display("FAIL mid_pre got=%0d,%0d,%0d exp=10,4,1", s_x, s_y, s_fc); end
    apply_reset(1);
    checks++; if (s_pins !== 14'h3000) begin failures++; $display("FAIL mid_pins got=%h exp=3000", s_pins); end
    checks++; if (s_fc !== 2'd0 || s_x !== 10'd0 || s_y !== 10'd0) begin failures++; $display("FAIL mid_state got=%0d,%0d,%0d exp=0,0,0", s_fc, s_x, s_y); end
    checks++; if (d_pins !== 14'h3000 || d_fc !== 16'h0) begin failures++; $display("FAIL mid_state_d got=%h,%0d exp=3000,0", d_pins, d_fc); end
    rst = 1'b1;
    for (int k = 1; k <= 450; k++) begin
      @(posedge clk); #1;
      ep = exp_pins(k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
      ec = exp_coord(k, S_HA, S_HT, S_VA, S_VT);
      checks++; if (s_pins !== ep) begin failures++; $display("FAIL mid_cold_pins k=%0d got=%h exp=%h", k, s_pins, ep); end
      checks++; if (s_coord !== ec) begin failures++; $display("FAIL mid_cold_coord k=%0d got=%h exp=%h", k, s_coord, ec); end
      ep = exp_pins(k, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB);
      checks++; if (d_pins !== ep) begin failures++; $display("FAIL mid_cold_pins_d k=%0d got=%h exp=%h", k, d_pins, ep); end
    end
  endtask

  initial begin
    d_ib = 4'hF;
    s_ib = 4'hF;
    test_reset();
    test_line_timing();
    test_alignment();
    test_frame_timing();
    test_wrap();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
